// File: rtl/arith_unit.sv
// arith_unit: 16-bit integer ALU with a registered 32-bit result
module arith_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [2:0]  opcode,
  output logic [31:0] out_arith
);
  logic [31:0] a_ext;
  logic [31:0] b_ext;
  logic [31:0] as_ext;
  logic [31:0] bs_ext;
  logic [31:0] prod_u;
  logic [31:0] prod_s;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        div_zero;
  logic [31:0] result;
  assign a_ext    = {16'h0000, in_a};
  assign b_ext    = {16'h0000, in_b};
  assign as_ext   = {{16{in_a[15]}}, in_a};
  assign bs_ext   = {{16{in_b[15]}}, in_b};
  assign prod_u   = a_ext * b_ext;
  assign prod_s   = as_ext * bs_ext;
  assign div_zero = in_b == 16'h0000;
  assign quot     = div_zero ? 16'hFFFF : in_a / in_b;
  assign rem      = div_zero ? in_a : in_a % in_b;
  always_comb begin
    result = 32'h0000_0000;
    case (opcode)
      3'd0: result = a_ext + b_ext;
      3'd1: result = a_ext - b_ext;
      3'd2: result = prod_u;
      3'd3: result = {16'h0000, quot};
      3'd4: result = {16'h0000, rem};
      3'd5: result = a_ext + 32'd1;
      3'd6: result = a_ext - 32'd1;
      3'd7: result = prod_s;
      default: result = 32'h0000_0000;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) out_arith <= 32'h0000_0000;
    else     out_arith <= result;
  end
endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit: randomized self-checking bench for arith_unit
module tb_arith_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic [2:0]  opcode = 3'd0;
  logic [31:0] out_arith;
  int checks = 0;
  int failures = 0;

  arith_unit dut (
    .clk(clk),
    .rst(rst),
    .in_a(in_a),
    .in_b(in_b),
    .opcode(opcode),
    .out_arith(out_arith)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input int unsigned a, input int unsigned b, input int unsigned op);
    shortint sa;
    shortint sb;
    int p;
    sa = shortint'(a);
    sb = shortint'(b);
    p = int'(sa) * int'(sb);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return (b == 0) ? 32'h0000_FFFF : a / b;
      4: return (b == 0) ? a : a % b;
      5: return a + 1;
      6: return a - 1;
      default: return p;
    endcase
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input int op, input logic r);
    in_a = a;
    in_b = b;
    opcode = op[2:0];
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] a;
    logic [15:0] b;
    int op;
    a = 16'($urandom);
    b = 16'($urandom);
    op = int'($urandom_range(0, 7));
    for (int i = 0; i < 2; i++) begin
      drive(a, b, op, 1'b1);
      checks++;
      if (out_arith !== 32'h0) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%08h exp=00000000", i, out_arith);
      end
    end
    drive(a, b, op, 1'b0);
    checks++;
    if (out_arith !== model(a, b, op)) begin
      failures++;
      $display("FAIL reset_release op=%0d got=%08h exp=%08h", op, out_arith, model(a, b, op));
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp_tab [8] = '{32'h0000000B, 32'hFFFFFFFD, 32'h0000001C, 32'h00000000,
                                 32'h00000004, 32'h00000005, 32'h00000003, 32'h0000001C};
    for (int op = 0; op < 8; op++) begin
      drive(16'd4, 16'd7, op, 1'b0);
      checks++;
      if (out_arith !== exp_tab[op]) begin
        failures++;
        $display("FAIL sweep op=%0d got=%08h exp=%08h", op, out_arith, exp_tab[op]);
      end
    end
  endtask

  task automatic test_edges();
    logic [15:0] ta [11] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF,
                             16'h8000, 16'h0064, 16'h0064, 16'hBEEF, 16'h1234};
    logic [15:0] tb [11] = '{16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF,
                             16'h0002, 16'h0007, 16'h0007, 16'h0000, 16'h0000};
    int          to [11] = '{0, 5, 6, 1, 2, 7, 7, 3, 4, 3, 4};
    logic [31:0] te [11] = '{32'h00010000, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFE0001, 32'h00000001, 32'hFFFF0000, 32'h0000000E,
                             32'h00000002, 32'h0000FFFF, 32'h00001234};
    for (int i = 0; i < 11; i++) begin
      drive(ta[i], tb[i], to[i], 1'b0);
      checks++;
      if (out_arith !== te[i]) begin
        failures++;
        $display("FAIL edge[%0d] op=%0d a=%04h b=%04h got=%08h exp=%08h", i, to[i], ta[i], tb[i], out_arith, te[i]);
      end
    end
  endtask

  task automatic test_opcode_truncation();
    int wide;
    wide = 9;
    drive(16'd4, 16'd7, wide, 1'b0);
    checks++;
    if (out_arith !== 32'hFFFFFFFD) begin
      failures++;
      $display("FAIL opcode_trunc got=%08h exp=FFFFFFFD", out_arith);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    int op;
    logic [31:0] e;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      op = int'($urandom_range(0, 7));
      e = model(a, b, op);
      drive(a, b, op, 1'b0);
      checks++;
      if (out_arith !== e) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%04h b=%04h got=%08h exp=%08h", i, op, a, b, out_arith, e);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(16'h1234, 16'h0002, 0, 1'b0);
    checks++;
    if (out_arith !== 32'h00001236) begin
      failures++;
      $display("FAIL mid_pre got=%08h exp=00001236", out_arith);
    end
    drive(16'h00FF, 16'h0101, 2, 1'b1);
    checks++;
    if (out_arith !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset got=%08h exp=00000000", out_arith);
    end
    drive(16'h0003, 16'h0002, 1, 1'b0);
    checks++;
    if (out_arith !== 32'h00000001) begin
      failures++;
      $display("FAIL mid_after got=%08h exp=00000001", out_arith);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_edges();
    test_opcode_truncation();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
